// File: rtl/bus_arbiter.sv
// Shares one single-port memory bus between the IF fetch port and the MEM data port.
// Data accesses win over fetches; results are latched per requester until the pipeline advances.
module bus_arbiter #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_if_o,
  output logic        stallreq_mem_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, DATA_BUSY, INST_BUSY} state_t;

  localparam logic [7:0] LP_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      r_state, w_state_next;
  logic        r_if_done, r_mem_done, w_if_done_next, w_mem_done_next;
  logic [7:0]  r_wait_cnt, w_wait_cnt_next;
  logic [31:0] r_if_data, r_mem_data, w_if_data_next, w_mem_data_next;
  logic        r_stb, r_we, r_err, w_stb_next, w_we_next, w_err_next;
  logic [3:0]  r_sel, w_sel_next;
  logic [31:0] r_addr, r_wdata, w_addr_next, w_wdata_next;
  logic        w_unused_stall;

  assign w_unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      r_wait_cnt <= 8'd0;
      r_if_data  <= 32'd0;
      r_mem_data <= 32'd0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_sel      <= 4'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
    end else begin
      r_state    <= w_state_next;
      r_if_done  <= w_if_done_next;
      r_mem_done <= w_mem_done_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_if_data  <= w_if_data_next;
      r_mem_data <= w_mem_data_next;
      r_stb      <= w_stb_next;
      r_we       <= w_we_next;
      r_err      <= w_err_next;
      r_sel      <= w_sel_next;
      r_addr     <= w_addr_next;
      r_wdata    <= w_wdata_next;
    end
  end

  // Done flags clear when the owning stage advances; a completion in the same cycle wins.
  always_comb begin
    w_state_next    = r_state;
    w_if_done_next  = r_if_done & stall_i[1];
    w_mem_done_next = r_mem_done & stall_i[4];
    w_wait_cnt_next = r_wait_cnt;
    w_if_data_next  = r_if_data;
    w_mem_data_next = r_mem_data;
    w_stb_next      = r_stb;
    w_we_next       = r_we;
    w_err_next      = 1'b0;
    w_sel_next      = r_sel;
    w_addr_next     = r_addr;
    w_wdata_next    = r_wdata;
    case (r_state)
      IDLE: begin
        w_stb_next = 1'b0;
        if (mem_ce_i && !r_mem_done) begin
          w_state_next    = DATA_BUSY;
          w_stb_next      = 1'b1;
          w_we_next       = mem_we_i;
          w_sel_next      = mem_sel_i;
          w_addr_next     = mem_addr_i;
          w_wdata_next    = mem_data_i;
          w_wait_cnt_next = 8'd0;
        end else if (if_ce_i && !r_if_done) begin
          w_state_next    = INST_BUSY;
          w_stb_next      = 1'b1;
          w_we_next       = 1'b0;
          w_sel_next      = 4'hF;
          w_addr_next     = if_addr_i;
          w_wait_cnt_next = 8'd0;
        end
      end
      DATA_BUSY, INST_BUSY: begin
        // An ack on the last allowed cycle still counts as a normal completion.
        if (bus_ack_i || r_wait_cnt == LP_LAST) begin
          w_state_next = IDLE;
          w_stb_next   = 1'b0;
          w_err_next   = ~bus_ack_i;
          if (r_state == DATA_BUSY) begin
            w_mem_done_next = 1'b1;
            if (!bus_ack_i)
              w_mem_data_next = 32'd0;
            else if (!r_we)
              w_mem_data_next = bus_data_i;
          end else begin
            w_if_done_next = 1'b1;
            w_if_data_next = bus_ack_i ? bus_data_i : 32'd0;
          end
        end else begin
          w_wait_cnt_next = r_wait_cnt + 8'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign stallreq_if_o  = if_ce_i & ~r_if_done & ~rst;
  assign stallreq_mem_o = mem_ce_i & ~r_mem_done & ~rst;
  assign if_data_o      = r_if_data;
  assign mem_data_o     = r_mem_data;
  assign bus_stb_o      = r_stb;
  assign bus_we_o       = r_we;
  assign bus_sel_o      = r_sel;
  assign bus_addr_o     = r_addr;
  assign bus_data_o     = r_wdata;
  assign bus_err_o      = r_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; each task drives one scenario and checks inline.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        stallreq_if_o;
  logic        stallreq_mem_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;
  logic        bus_ack_i;
  logic        bus_err_o;

  int checks = 0;
  int failures = 0;

  bus_arbiter #(.ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
    .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
    .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_i = 6'd0; if_ce_i = 1'b0; if_addr_i = 32'd0;
    mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'd0; mem_addr_i = 32'd0;
    mem_data_i = 32'd0; bus_data_i = 32'd0; bus_ack_i = 1'b0;
    tick(); tick();
    checks++; if (bus_stb_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_stb: got %b expected 0", bus_stb_o); end
    checks++; if (if_data_o !== 32'd0) begin failures++; $display("[TB] FAIL reset_if_data: got %h expected 0", if_data_o); end
    checks++; if (mem_data_o !== 32'd0) begin failures++; $display("[TB] FAIL reset_mem_data: got %h expected 0", mem_data_o); end
    checks++; if (bus_err_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", bus_err_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch_basic();
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0000;
    tick();
    checks++; if (bus_stb_o !== 1'b1) begin failures++; $display("[TB] FAIL fetch_stb: got %b expected 1", bus_stb_o); end
    checks++; if ({bus_we_o, bus_sel_o} !== 5'b0_1111) begin failures++; $display("[TB] FAIL fetch_we_sel: got %b expected 01111", {bus_we_o, bus_sel_o}); end
    checks++; if (stallreq_if_o !== 1'b1) begin failures++; $display("[TB] FAIL fetch_stallreq_busy: got %b expected 1", stallreq_if_o); end
    bus_ack_i = 1'b1; bus_data_i = 32'h3401_1100;
    tick();
    bus_ack_i = 1'b0;
    checks++; if (bus_stb_o !== 1'b0) begin failures++; $display("[TB] FAIL fetch_stb_one_cycle: got %b expected 0", bus_stb_o); end
    checks++; if (if_data_o !== 32'h3401_1100) begin failures++; $display("[TB] FAIL fetch_data: got %h expected 34011100", if_data_o); end
    checks++; if (stallreq_if_o !== 1'b0) begin failures++; $display("[TB] FAIL fetch_stallreq_done: got %b expected 0", stallreq_if_o); end
    if_ce_i = 1'b0;
    tick();
    bus_ack_i = 1'b1; bus_data_i = 32'hFFFF_FFFF;
    tick();
    bus_ack_i = 1'b0;
    checks++; if (if_data_o !== 32'h3401_1100) begin failures++; $display("[TB] FAIL idle_ack_if: got %h expected 34011100", if_data_o); end
    checks++; if (mem_data_o !== 32'd0) begin failures++; $display("[TB] FAIL idle_ack_mem: got %h expected 0", mem_data_o); end
    checks++; if (bus_stb_o !== 1'b0) begin failures++; $display("[TB] FAIL idle_ack_stb: got %b expected 0", bus_stb_o); end
  endtask

  task automatic test_concurrent();
    stall_i = 6'b010010;
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0004;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h0000_0100;
    tick();
    checks++; if (bus_addr_o !== 32'h0000_0100) begin failures++; $display("[TB] FAIL conc_first_addr: got %h expected 00000100", bus_addr_o); end
    checks++; if ({stallreq_if_o, stallreq_mem_o} !== 2'b11) begin failures++; $display("[TB] FAIL conc_stallreqs: got %b expected 11", {stallreq_if_o, stallreq_mem_o}); end
    tick(); tick();
    checks++; if ({bus_stb_o, bus_addr_o} !== {1'b1, 32'h0000_0100}) begin failures++; $display("[TB] FAIL conc_hold: got %b/%h expected 1/00000100", bus_stb_o, bus_addr_o); end
    bus_ack_i = 1'b1; bus_data_i = 32'hDEAD_BEEF;
    tick();
    bus_ack_i = 1'b0;
    checks++; if (mem_data_o !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL conc_load_data: got %h expected deadbeef", mem_data_o); end
    checks++; if ({bus_stb_o, stallreq_mem_o, stallreq_if_o} !== 3'b001) begin failures++; $display("[TB] FAIL conc_idle_gap: got %b expected 001", {bus_stb_o, stallreq_mem_o, stallreq_if_o}); end
    tick();
    checks++; if ({bus_stb_o, bus_addr_o} !== {1'b1, 32'h0000_0004}) begin failures++; $display("[TB] FAIL conc_fetch_issue: got %b/%h expected 1/00000004", bus_stb_o, bus_addr_o); end
    bus_ack_i = 1'b1; bus_data_i = 32'h8C22_0000;
    tick();
    bus_ack_i = 1'b0;
    checks++; if ({if_data_o, stallreq_if_o} !== {32'h8C22_0000, 1'b0}) begin failures++; $display("[TB] FAIL conc_fetch_data: got %h/%b expected 8c220000/0", if_data_o, stallreq_if_o); end
    stall_i = 6'd0; if_ce_i = 1'b0; mem_ce_i = 1'b0;
    tick();
  endtask

  task automatic test_store();
    stall_i = 6'b010000;
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
    mem_addr_i = 32'h0000_0200; mem_data_i = 32'h0000_ABCD;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o} !== {1'b1, 1'b1, 4'b0011, 32'h0000_0200, 32'h0000_ABCD}) begin
        failures++;
        $display("[TB] FAIL store_fields[%0d]: got stb=%b we=%b sel=%b addr=%h data=%h expected 1/1/0011/00000200/0000abcd", i, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o);
      end
    end
    bus_ack_i = 1'b1; bus_data_i = 32'h1234_5678;
    tick();
    bus_ack_i = 1'b0;
    checks++; if (mem_data_o !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL store_mem_data: got %h expected deadbeef", mem_data_o); end
    checks++; if ({bus_stb_o, stallreq_mem_o} !== 2'b00) begin failures++; $display("[TB] FAIL store_done: got %b expected 00", {bus_stb_o, stallreq_mem_o}); end
    stall_i = 6'd0; mem_ce_i = 1'b0; mem_we_i = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    int errs;
    stall_i = 6'b000010;
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0008;
    tick();
    n = 0; errs = 0;
    while (bus_stb_o === 1'b1 && n < 40) begin
      n++;
      if (bus_err_o === 1'b1) errs++;
      tick();
    end
    checks++; if (n !== 16) begin failures++; $display("[TB] FAIL timeout_stb_cycles: got %0d expected 16", n); end
    checks++; if (errs !== 0 || bus_err_o !== 1'b1) begin failures++; $display("[TB] FAIL timeout_err_pulse: early=%0d err=%b expected 0/1", errs, bus_err_o); end
    checks++; if (if_data_o !== 32'd0) begin failures++; $display("[TB] FAIL timeout_if_data: got %h expected 0", if_data_o); end
    checks++; if (stallreq_if_o !== 1'b0) begin failures++; $display("[TB] FAIL timeout_stallreq: got %b expected 0", stallreq_if_o); end
    tick();
    checks++; if ({bus_err_o, bus_stb_o} !== 2'b00) begin failures++; $display("[TB] FAIL timeout_err_single: got %b expected 00", {bus_err_o, bus_stb_o}); end
    stall_i = 6'd0; if_ce_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    stall_i = 6'b010010;
    if_ce_i = 1'b1; if_addr_i = 32'h0000_000C;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h0000_0300;
    tick();
    checks++; if ({bus_stb_o, stallreq_mem_o, stallreq_if_o} !== 3'b111) begin failures++; $display("[TB] FAIL rstmid_busy: got %b expected 111", {bus_stb_o, stallreq_mem_o, stallreq_if_o}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus_stb_o, stallreq_mem_o, stallreq_if_o} !== 3'b000) begin failures++; $display("[TB] FAIL rstmid_async: got %b expected 000", {bus_stb_o, stallreq_mem_o, stallreq_if_o}); end
    #1 rst = 1'b0;
    mem_ce_i = 1'b0; stall_i = 6'd0;
    tick();
    checks++; if ({bus_stb_o, bus_addr_o} !== {1'b1, 32'h0000_000C}) begin failures++; $display("[TB] FAIL rstmid_refetch: got %b/%h expected 1/0000000c", bus_stb_o, bus_addr_o); end
    bus_ack_i = 1'b1; bus_data_i = 32'h0022_1820;
    tick();
    bus_ack_i = 1'b0;
    checks++; if ({if_data_o, stallreq_if_o} !== {32'h0022_1820, 1'b0}) begin failures++; $display("[TB] FAIL rstmid_fetch_data: got %h/%b expected 00221820/0", if_data_o, stallreq_if_o); end
    if_ce_i = 1'b0;
    tick();
  endtask

  task automatic test_stall_hold();
    stall_i = 6'b000010;
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0010;
    tick();
    bus_ack_i = 1'b1; bus_data_i = 32'h1111_1111;
    tick();
    bus_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus_stb_o, stallreq_if_o, if_data_o} !== {1'b0, 1'b0, 32'h1111_1111}) begin
        failures++;
        $display("[TB] FAIL hold_no_refetch[%0d]: got stb=%b req=%b data=%h expected 0/0/11111111", i, bus_stb_o, stallreq_if_o, if_data_o);
      end
    end
    stall_i = 6'd0; if_addr_i = 32'h0000_0014;
    tick();
    checks++; if ({bus_stb_o, stallreq_if_o} !== 2'b01) begin failures++; $display("[TB] FAIL hold_cleared: got %b expected 01", {bus_stb_o, stallreq_if_o}); end
    tick();
    checks++; if ({bus_stb_o, bus_addr_o} !== {1'b1, 32'h0000_0014}) begin failures++; $display("[TB] FAIL hold_next_fetch: got %b/%h expected 1/00000014", bus_stb_o, bus_addr_o); end
    bus_ack_i = 1'b1; bus_data_i = 32'h2222_2222;
    tick();
    bus_ack_i = 1'b0;
    checks++; if (if_data_o !== 32'h2222_2222) begin failures++; $display("[TB] FAIL hold_next_data: got %h expected 22222222", if_data_o); end
    if_ce_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_concurrent();
    test_store();
    test_timeout();
    test_reset_mid();
    test_stall_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Shares one external single-port memory bus between the instruction-fetch port (IF stage) and the data-access port (MEM stage) of the five-stage MIPS32 pipeline. It grants one transaction at a time with fixed data-over-fetch priority and latches returned data per requester. It raises per-stage stall requests to `ctrl` until each requester's result is available, and aborts hung transactions via an acknowledge timeout.

## Interface
- `ACK_TIMEOUT`, 16: max cycles `bus_stb_o` may wait for `bus_ack_i` before abort (2..255).
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-high
- `stall_i`  in  6  stall vector from `ctrl` (bit1 = IF/ID hold, bit4 = MEM/WB hold)
- `if_ce_i`  in  1  fetch request valid
- `if_addr_i`  in  32  fetch address
- `if_data_o`  out  32  latched instruction
- `mem_ce_i`  in  1  data request valid
- `mem_we_i`  in  1  1 = store
- `mem_sel_i`  in  4  byte lane enables
- `mem_addr_i`  in  32  data address
- `mem_data_i`  in  32  store data
- `mem_data_o`  out  32  latched load data
- `stallreq_if_o`  out  1  fetch not complete
- `stallreq_mem_o`  out  1  data access not complete
- `bus_stb_o`  out  1  bus request (registered)
- `bus_we_o`, `bus_sel_o`(4), `bus_addr_o`(32), `bus_data_o`(32)  out  transaction fields (registered)
- `bus_data_i`  in  32  read data, valid with ack
- `bus_ack_i`  in  1  transaction complete
- `bus_err_o`  out  1  one-cycle pulse on timeout abort

## Operation
- States: IDLE, DATA_BUSY, INST_BUSY.
- Flags `if_done`, `mem_done`. `stallreq_if_o = if_ce_i & ~if_done`; `stallreq_mem_o = mem_ce_i & ~mem_done` (combinational).
- IDLE: if `mem_ce_i & ~mem_done` → DATA_BUSY, load bus fields from mem port. Else if `if_ce_i & ~if_done` → INST_BUSY, load `if_addr_i`, `we=0`, `sel=4'hF`. Else stay, `bus_stb_o=0`.
- Simultaneous requests: data wins; fetch waits.
- BUSY: `bus_stb_o=1`; all bus fields held stable until ack or abort.
- On `bus_ack_i` in BUSY: read → latch `bus_data_i` into requester's result reg; write → result reg unchanged; set requester's done flag; `bus_stb_o=0`; → IDLE.
- Timeout: wait counter reset on entry to BUSY, increments each BUSY cycle without ack; when it reaches `ACK_TIMEOUT-1` with no ack: abort, result reg ← 0, set done, `bus_err_o=1` one cycle, → IDLE.
- `if_done` cleared on cycles with `stall_i[1]==0`; `mem_done` cleared on cycles with `stall_i[4]==0`. Set has priority over clear in the same cycle.
- `bus_ack_i` outside BUSY is ignored.
- Requester dropping `ce` mid-transaction: transaction still completes; the result is latched and discarded by the next clear.

## Timing
- Reset (async): state IDLE; all outputs, result regs, flags and counter = 0; `bus_stb_o` deasserts immediately, without waiting for a clock edge.
- Request seen in IDLE at edge n → `bus_stb_o` high after edge n. Ack sampled at edge n+k (k≥1) → `*_data_o` valid and stallreq low after edge n+k.
- Minimum read latency: 2 cycles from request to deasserted stallreq.
- One IDLE cycle always separates consecutive transactions.
- Max `bus_stb_o` high: `ACK_TIMEOUT` cycles.
- Concurrent fetch and data: data completes first; fetch starts one cycle later; both stallreqs remain high until each is individually done.

## Test plan
- Reset, then fetch `0x0000_0000` with 1-cycle ack returning `0x3401_1100`: `bus_stb_o` high 1 cycle, `if_data_o=0x3401_1100`, `stallreq_if_o` low 2 cycles after request.
- Simultaneous fetch `0x04` and load `0x100` (data `0xDEAD_BEEF`, 3-cycle ack): load issued first, `mem_data_o=0xDEAD_BEEF`; fetch issued after one IDLE cycle.
- Store `0x200`, sel `4'b0011`, data `0x0000_ABCD`: `bus_we_o=1` and `bus_sel_o=0011` stable until ack; `mem_data_o` unchanged.
- No ack with `ACK_TIMEOUT=16`: abort after 16 stb cycles, one `bus_err_o` pulse, `if_data_o=0`, stallreq drops.
- Assert `rst` mid DATA_BUSY: `bus_stb_o` and stallreqs fall without waiting for a clock edge; after release, a new fetch completes normally.
- `stall_i[1]=1` held 3 cycles after fetch done: `if_done` persists, no re-fetch; `stall_i[1]=0` then clears it and the next address is fetched.
